// File: rtl/xor_parity_accum_pkg.sv
// ---------------------------------------------------------------------------
// xor_parity_accum_pkg
// Shared definitions for the serial parity accumulator:
//   - state_t     : FSM state encodings (ACCUM / DONE / CHECK)
//   - PAR_EVEN/ODD: parity sense constants
//   - cnt_width() : width of the in-frame bit counter for a given frame size
// ---------------------------------------------------------------------------
package xor_parity_accum_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DONE  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // A one-bit frame still needs a one-bit counter so the port/compare
    // widths stay legal.
    function automatic int cnt_width(input int frame_bits);
        return (frame_bits > 1) ? $clog2(frame_bits) : 1;
    endfunction

endpackage

// File: rtl/xor_parity_accum_xor_gate.sv
// ---------------------------------------------------------------------------
// xor_gate
// Existing 2-input XOR cell; the accumulator uses it to fold each incoming
// bit into the running parity.
// Ports:
//   a, b : operands
//   y    : a ^ b
// ---------------------------------------------------------------------------
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_parity_accum.sv
// ---------------------------------------------------------------------------
// xor_parity_accum
// Serial parity accumulator. XOR-folds FRAME_BITS accepted bits into one
// parity bit, offers it on a valid/ready output, then re-arms.
//
// Optional feature macro: XOR_PARITY_CHECK_EN
//   When defined, the bit after each frame is taken as the received parity
//   bit and compared against the computed one; the outcome is on parity_err.
//
// Parameters:
//   FRAME_BITS  data bits per frame (1..256)
//   ODD_PARITY  0 = even parity, 1 = odd parity
//   CNT_W       width of frame_count (wraps)
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bit_in        serial data bit
//   bit_valid     bit_in valid
//   bit_ready     bit accepted when bit_valid & bit_ready
//   parity_out    frame parity, stable while parity_valid
//   parity_valid  result available
//   parity_ready  result consumed when parity_valid & parity_ready
//   busy          partial frame held or result pending
//   frame_count   number of completed result transfers
//   parity_err    (XOR_PARITY_CHECK_EN only) received parity mismatch
// ---------------------------------------------------------------------------
module xor_parity_accum
    import xor_parity_accum_pkg::*;
#(
    parameter int FRAME_BITS = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             parity_out,
    output logic             parity_valid,
    input  logic             parity_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
`ifdef XOR_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int             CW        = cnt_width(FRAME_BITS);
    localparam logic [CW-1:0]  LAST_IDX  = CW'(FRAME_BITS - 1);
    localparam logic           PAR_SENSE = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

    state_t           state;
    state_t           state_next;
    logic             acc;
    logic             acc_xor;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             bit_accept;
    logic             result_take;
    logic             frame_end;

    xor_gate u_xor (
        .a (acc),
        .b (bit_in),
        .y (acc_xor)
    );

    assign bit_accept  = bit_valid & bit_ready;
    assign result_take = parity_valid & parity_ready;
    assign frame_end   = (cnt == LAST_IDX);
    assign frame_count = frame_cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. With the check feature the frame gets one extra
    // bit (the received parity) handled in CHECK before the result is shown.
    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: begin
                if (bit_accept && frame_end) begin
`ifdef XOR_PARITY_CHECK_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef XOR_PARITY_CHECK_EN
                if (bit_accept) begin
                    state_next = ST_DONE;
                end
`else
                state_next = ST_ACCUM;
`endif
            end
            ST_DONE: begin
                if (result_take) begin
                    state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase
    end

    // Output decode. parity_out is forced low outside DONE so it reads 0
    // after reset regardless of the parity sense.
    always_comb begin
        bit_ready    = 1'b0;
        parity_valid = 1'b0;
        parity_out   = 1'b0;
        case (state)
            ST_ACCUM: bit_ready = 1'b1;
            ST_CHECK: begin
`ifdef XOR_PARITY_CHECK_EN
                bit_ready = 1'b1;
`endif
            end
            ST_DONE: begin
                parity_valid = 1'b1;
                parity_out   = acc ^ PAR_SENSE;
            end
            default: bit_ready = 1'b0;
        endcase
        busy = (state != ST_ACCUM) | (cnt != '0);
    end

    // Datapath: running parity, in-frame bit index and frame counter.
    // acc only folds data bits; the received parity bit in CHECK leaves it
    // alone so parity_out stays the computed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= 1'b0;
            cnt         <= '0;
            frame_cnt_q <= '0;
`ifdef XOR_PARITY_CHECK_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (state == ST_ACCUM && bit_accept) begin
                acc <= acc_xor;
                cnt <= frame_end ? '0 : cnt + CW'(1);
            end
`ifdef XOR_PARITY_CHECK_EN
            if (state == ST_CHECK && bit_accept) begin
                parity_err <= (acc ^ PAR_SENSE) ^ bit_in;
            end
`endif
            if (result_take) begin
                acc         <= 1'b0;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_accum.sv
// ---------------------------------------------------------------------------
// tb_xor_parity_accum
// Drives an even-parity and an odd-parity instance (the odd one with a
// narrow frame counter so wrap-around happens) from the same stimulus and
// compares both against a frame-level model every cycle.
// Honours XOR_PARITY_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_xor_parity_accum;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W_ODD  = 3;
`ifdef XOR_PARITY_CHECK_EN
    localparam int FRAME_LEN  = FRAME_BITS + 1;
`else
    localparam int FRAME_LEN  = FRAME_BITS;
`endif

    logic clk = 1'b0;
    logic rst;
    logic bit_in;
    logic bit_valid;
    logic parity_ready;

    logic        ready_e, valid_e, out_e, busy_e;
    logic [15:0] fc_e;
    logic        ready_o, valid_o, out_o, busy_o;
    logic [CNT_W_ODD-1:0] fc_o;
`ifdef XOR_PARITY_CHECK_EN
    logic        err_e, err_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xor_parity_accum #(.FRAME_BITS(FRAME_BITS), .ODD_PARITY(0), .CNT_W(16)) dut_even (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (ready_e),
        .parity_out   (out_e),
        .parity_valid (valid_e),
        .parity_ready (parity_ready),
        .busy         (busy_e),
        .frame_count  (fc_e)
`ifdef XOR_PARITY_CHECK_EN
        ,
        .parity_err   (err_e)
`endif
    );

    xor_parity_accum #(.FRAME_BITS(FRAME_BITS), .ODD_PARITY(1), .CNT_W(CNT_W_ODD)) dut_odd (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (ready_o),
        .parity_out   (out_o),
        .parity_valid (valid_o),
        .parity_ready (parity_ready),
        .busy         (busy_o),
        .frame_count  (fc_o)
`ifdef XOR_PARITY_CHECK_EN
        ,
        .parity_err   (err_o)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: collects accepted bits in a queue, and once a full
    // frame is in, holds a pending result until the consumer takes it.
    bit m_bits[$];
    bit m_pending = 0;
    bit m_par     = 0;
    int m_frames  = 0;
    bit m_err_e   = 0;
    bit m_err_o   = 0;
    bit m_live    = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_bits.delete();
            m_pending = 0;
            m_par     = 0;
            m_frames  = 0;
            m_err_e   = 0;
            m_err_o   = 0;
            m_live    = 1;
        end else if (m_live) begin
            if (m_pending) begin
                if (parity_ready) begin
                    m_pending = 0;
                    m_frames++;
                    m_bits.delete();
                end
            end else if (bit_valid) begin
                m_bits.push_back(bit_in);
                if (m_bits.size() == FRAME_LEN) begin
                    m_par = 0;
                    for (int i = 0; i < FRAME_BITS; i++) m_par ^= m_bits[i];
`ifdef XOR_PARITY_CHECK_EN
                    m_err_e = m_par ^ m_bits[FRAME_BITS];
                    m_err_o = ~m_par ^ m_bits[FRAME_BITS];
`endif
                    m_pending = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            checkOutput("bit_ready_even",    ready_e, !m_pending);
            checkOutput("bit_ready_odd",     ready_o, !m_pending);
            checkOutput("parity_valid_even", valid_e, m_pending);
            checkOutput("parity_valid_odd",  valid_o, m_pending);
            checkOutput("busy_even", busy_e, (m_pending || m_bits.size() != 0));
            checkOutput("busy_odd",  busy_o, (m_pending || m_bits.size() != 0));
            checkOutput("frame_count_even", fc_e, 32'(m_frames % 65536));
            checkOutput("frame_count_odd",  fc_o, 32'(m_frames % (1 << CNT_W_ODD)));
            if (m_pending) begin
                checkOutput("parity_out_even", out_e, m_par);
                checkOutput("parity_out_odd",  out_o, !m_par);
            end
`ifdef XOR_PARITY_CHECK_EN
            checkOutput("parity_err_even", err_e, m_err_e);
            checkOutput("parity_err_odd",  err_o, m_err_o);
`endif
        end
    end

    task automatic send_bit(input logic b);
        int  n;
        logic r;
        n = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        do begin
            @(negedge clk);
            r = ready_e;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) checkOutput("send_timeout", 0, 1);
        bit_valid = 1'b0;
    endtask

    // Sends one frame LSB first, plus the received parity bit when checking.
    task automatic applyStimulus(input logic [7:0] data, input logic p);
        logic [7:0] d;
        d = data;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef XOR_PARITY_CHECK_EN
        send_bit(p);
`else
        if (p) begin end
`endif
    endtask

    // Waits for the result, checks it against hand-computed values, holds
    // off the consumer for 'hold' cycles, then takes it.
    task automatic take_result(input logic exp_e, input logic exp_o,
                               input int hold, input int exp_fc);
        int n;
        n = 0;
        @(negedge clk);
        while (!valid_e && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid_e) begin
            checkOutput("result_timeout", 0, 1);
            return;
        end
        checkOutput("lit_parity_out_even", out_e, exp_e);
        checkOutput("lit_parity_out_odd",  out_o, exp_o);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("lit_hold_valid",       valid_e, 1);
            checkOutput("lit_hold_bit_ready",   ready_e, 0);
            checkOutput("lit_hold_parity_out",  out_e, exp_e);
            checkOutput("lit_hold_frame_count", fc_e, exp_fc - 1);
        end
        parity_ready = 1'b1;
        @(posedge clk);
        #1;
        parity_ready = 1'b0;
        @(negedge clk);
        checkOutput("lit_frame_count", fc_e, exp_fc);
        checkOutput("lit_valid_dropped", valid_e, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        parity_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("lit_reset_bit_ready",    ready_e, 1);
        checkOutput("lit_reset_parity_valid", valid_e, 0);
        checkOutput("lit_reset_busy",         busy_e, 0);
        checkOutput("lit_reset_frame_count",  fc_e, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bits 1,0,1,1,0,0,1,0: four ones.
        applyStimulus(8'b0100_1101, 1'b0);
        take_result(1'b0, 1'b1, 0, 1);
        // Bits 1,1,1,0,0,0,0,0: three ones.
        applyStimulus(8'b0000_0111, 1'b1);
        take_result(1'b1, 1'b0, 0, 2);
        // All zeros, consumer stalls for 5 cycles.
        applyStimulus(8'h00, 1'b0);
        take_result(1'b0, 1'b1, 5, 3);

        // Reset after 4 accepted bits discards the partial frame.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("lit_midreset_busy",        busy_e, 0);
        checkOutput("lit_midreset_frame_count", fc_e, 0);
        @(posedge clk);
        #1;
        applyStimulus(8'hFF, 1'b0);
        take_result(1'b0, 1'b1, 0, 1);

`ifdef XOR_PARITY_CHECK_EN
        // Data 0x01 has parity 1; a received 0 is an error, a 1 is not.
        applyStimulus(8'h01, 1'b0);
        take_result(1'b1, 1'b0, 0, 2);
        checkOutput("lit_parity_err_set", err_e, 1);
        applyStimulus(8'h01, 1'b1);
        take_result(1'b1, 1'b0, 0, 3);
        checkOutput("lit_parity_err_clear", err_e, 0);
`endif

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            bit_valid    = ($urandom_range(0, 3) != 0);
            bit_in       = 1'($urandom_range(0, 1));
            parity_ready = ($urandom_range(0, 2) != 0);
            rst          = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
        end
        rst          = 1'b0;
        bit_valid    = 1'b0;
        parity_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
